// File: rtl/uram_bank_array.sv
// Multi-bank UltraRAM store: NUM_BANKS columns share one address, masked writes, pipelined range-checked reads.
// Define URAM_INIT_CLEAR_EN to add a power-up/reset sweep that zeroes every location.
module uram_bank_column #(
  parameter int W     = 72,
  parameter int DEPTH = 12000,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic          rd_zero,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  (* ram_style = "ultra" *) logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;

  // Output register doubles as the zero source for out-of-range reads.
  always_ff @(posedge clk)
    if (rst)            rdata_q <= '0;
    else if (rd_zero)   rdata_q <= '0;
    else if (en && !we) rdata_q <= mem[addr];

  assign rdata = rdata_q;
endmodule

module uram_bank_array #(
  parameter int NUM_BANKS = 16,
  parameter int BANK_W    = 72,
  parameter int DEPTH     = 12000,
  parameter int RD_LAT    = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AW-1:0]               req_addr,
  input  logic [NUM_BANKS-1:0]        req_bank_mask,
  input  logic [NUM_BANKS*BANK_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [NUM_BANKS*BANK_W-1:0] rsp_rdata,
  output logic                        rsp_err,
  output logic                        wr_drop,
  output logic                        busy
);
  localparam int DW = NUM_BANKS * BANK_W;

  logic acc, in_rng, rd_acc, clr_act;
  logic [AW-1:0] clr_addr;
  logic [NUM_BANKS-1:0][BANK_W-1:0] bank_rdata;
  logic [RD_LAT:1] vld_pipe_q, vld_pipe_d, err_pipe_q, err_pipe_d;
  logic wr_drop_q, wr_drop_d;

`ifdef URAM_INIT_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + AW'(1);
      if (clr_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
    end
  end

  // Reset parks the FSM in CLEAR; the sweep itself starts once rst drops.
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end

  assign busy     = (state_q == CLEAR) && !rst;
  assign clr_act  = busy;
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_act  = 1'b0;
  assign clr_addr = '0;
`endif

  assign req_ready = !rst && !busy;
  assign acc       = req_valid && req_ready;
  assign in_rng    = {1'b0, req_addr} < (AW+1)'(DEPTH);
  assign rd_acc    = acc && !req_we;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    uram_bank_column #(.W(BANK_W), .DEPTH(DEPTH), .AW(AW)) u_col (
      .clk     (clk),
      .rst     (rst),
      .en      (clr_act || (acc && in_rng && (!req_we || req_bank_mask[i]))),
      .we      (clr_act || req_we),
      .rd_zero (rd_acc && !in_rng),
      .addr    (clr_act ? clr_addr : req_addr),
      .wdata   (clr_act ? '0 : req_wdata[BANK_W*i +: BANK_W]),
      .rdata   (bank_rdata[i])
    );
  end

  always_comb begin
    vld_pipe_d    = '0;
    err_pipe_d    = '0;
    vld_pipe_d[1] = rd_acc;
    err_pipe_d[1] = rd_acc && !in_rng;
    for (int k = 2; k <= RD_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      err_pipe_d[k] = err_pipe_q[k-1];
    end
    wr_drop_d = acc && req_we && !in_rng;
  end

  always_ff @(posedge clk)
    if (rst) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      err_pipe_q <= err_pipe_d;
      wr_drop_q  <= wr_drop_d;
    end

  // Data stages only advance with a valid read so the output holds between responses.
  if (RD_LAT == 1) begin : g_lat1
    assign rsp_rdata = bank_rdata;
  end else begin : g_latn
    logic [RD_LAT-1:1][DW-1:0] stg_q, stg_d;
    always_comb begin
      stg_d = stg_q;
      if (vld_pipe_q[1]) stg_d[1] = bank_rdata;
      for (int k = 2; k < RD_LAT; k++)
        if (vld_pipe_q[k]) stg_d[k] = stg_q[k-1];
    end
    always_ff @(posedge clk)
      if (rst) stg_q <= '0;
      else     stg_q <= stg_d;
    assign rsp_rdata = stg_q[RD_LAT-1];
  end

  assign rsp_valid = vld_pipe_q[RD_LAT];
  assign rsp_err   = err_pipe_q[RD_LAT];
  assign wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_uram_bank_array.sv
// Randomized bench for uram_bank_array against a queue/array reference model; follows URAM_INIT_CLEAR_EN.
module tb_uram_bank_array;
  localparam int NB     = 16;
  localparam int BW     = 72;
  localparam int DEPTH  = 12000;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = NB * BW;

  logic clk, rst, req_valid, req_ready, req_we, rsp_valid, rsp_err, wr_drop, busy;
  logic [AW-1:0] req_addr;
  logic [NB-1:0] req_bank_mask;
  logic [W-1:0]  req_wdata, rsp_rdata;

  uram_bank_array #(.NUM_BANKS(NB), .BANK_W(BW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_bank_mask(req_bank_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .wr_drop(wr_drop),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       err;
    logic [W-1:0] data;
  } rsp_t;

  logic [W-1:0] mem [DEPTH];
  rsp_t         q [$];
  logic [W-1:0] last;
  int n_chk, n_err, cyc, clr_left, drop_due;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive request, check outputs of this cycle, then update the model.
  task automatic step(input logic r, input logic v, input logic we, input int addr,
                      input logic [NB-1:0] m, input logic [W-1:0] d);
    logic exp_busy, exp_v;
    rsp_t e;
    rst = r; req_valid = v; req_we = we; req_addr = addr[AW-1:0];
    req_bank_mask = m; req_wdata = d;
    @(negedge clk);
    exp_busy = !r && clr_left > 0;
    chk("busy", 128'(busy), 128'(exp_busy));
    chk("req_ready", 128'(req_ready), 128'(!r && !exp_busy));
    exp_v = q.size() > 0 && q[0].due == cyc;
    if (exp_v) begin
      e = q.pop_front();
      last = e.data;
      chk("rsp_err", 128'(rsp_err), 128'(e.err));
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_v));
    chk("wr_drop", 128'(wr_drop), 128'(drop_due == cyc));
    for (int b = 0; b < NB; b++)
      chk($sformatf("rdata_bank%0d", b), 128'(rsp_rdata[BW*b +: BW]), 128'(last[BW*b +: BW]));
    if (v && !r && !exp_busy) begin
      if (addr >= DEPTH) begin
        if (we) drop_due = cyc + 1;
        else    q.push_back('{cyc + RD_LAT, 1'b1, '0});
      end else if (we) begin
        for (int b = 0; b < NB; b++)
          if (m[b]) mem[addr][BW*b +: BW] = d[BW*b +: BW];
      end else begin
        q.push_back('{cyc + RD_LAT, 1'b0, mem[addr]});
      end
    end
    if (r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      last = '0;
      drop_due = -1;
`ifdef URAM_INIT_CLEAR_EN
      clr_left = DEPTH;
      foreach (mem[i]) mem[i] = '0;
`endif
    end else if (exp_busy) begin
      clr_left--;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] d;
    int a, ra[4];
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_bank_mask = '0; req_wdata = '0;
    n_chk = 0; n_err = 0; cyc = 0; clr_left = 0; drop_due = -1; last = '0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, '0, '0);

`ifdef URAM_INIT_CLEAR_EN
    // Sweep restarted by rst after 30 cycles; requests offered meanwhile are refused.
    repeat (30) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), '1, rnd_w());
    step(1'b1, 1'b0, 1'b0, 0, '0, '0);
    while (clr_left > 0) step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, DEPTH-1)), '1, rnd_w());
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, i, '0, '0);
`else
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, i, '1, rnd_w());
`endif
    idle(RD_LAT + 1);

    // bank i holds i
    for (int i = 0; i < NB; i++) d[BW*i +: BW] = BW'(i);
    step(1'b0, 1'b1, 1'b1, 5, '1, d);
    step(1'b0, 1'b1, 1'b0, 5, '0, '0);
    idle(RD_LAT + 1);

    // partial mask over a full write
    step(1'b0, 1'b1, 1'b1, 7, '1, {(W/8){8'hAA}});
    step(1'b0, 1'b1, 1'b1, 7, NB'(3), {(W/8){8'h55}});
    step(1'b0, 1'b1, 1'b0, 7, '0, '0);
    step(1'b0, 1'b1, 1'b1, 9, '0, rnd_w());
    step(1'b0, 1'b1, 1'b1, 9, '1, rnd_w());
    step(1'b0, 1'b1, 1'b0, 9, '0, '0);
    idle(RD_LAT + 1);

    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, i, '0, '0);
    idle(RD_LAT + 1);

    // out-of-range read and write, then range edges
    step(1'b0, 1'b1, 1'b0, DEPTH, '0, '0);
    step(1'b0, 1'b1, 1'b1, DEPTH + 1, '1, rnd_w());
    step(1'b0, 1'b1, 1'b0, (1 << AW) - 1, '0, '0);
    step(1'b0, 1'b1, 1'b0, DEPTH - 1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1, '0, '0);
    idle(RD_LAT + 1);

    // reset lands one cycle before the first response
    for (int i = 0; i < 4; i++) ra[i] = int'($urandom_range(0, DEPTH-1));
    for (int i = 0; i < RD_LAT - 1; i++) step(1'b0, 1'b1, 1'b0, ra[i], '0, '0);
    step(1'b1, 1'b1, 1'b0, ra[3], '0, '0);
    idle(RD_LAT + 2);
    while (clr_left > 0) idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, ra[i], '0, '0);
    idle(RD_LAT + 1);

    repeat (3000) begin
      int sel;
      logic r;
      sel = int'($urandom_range(0, 99));
      if (sel < 10)      a = int'($urandom_range(DEPTH, (1 << AW) - 1));
      else if (sel < 55) a = int'($urandom_range(0, 15));
      else               a = int'($urandom_range(0, DEPTH-1));
      r = 1'b0;
`ifndef URAM_INIT_CLEAR_EN
      r = ($urandom_range(0, 99) == 0);
`endif
      step(r, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), a,
           ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom), rnd_w());
    end
    idle(RD_LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
